// File: rtl/matrix_stream_loader_pkg.sv
// Shared sizing, flat-bus offset helper and loader state encoding for the
// matrix multiplier front end.
package matrix_pkg;

  localparam int unsigned BIT_SIZE     = 8;
  localparam int unsigned ROW_COL_SIZE = 3;
  localparam int unsigned LINE_SIZE    = BIT_SIZE * ROW_COL_SIZE;
  localparam int unsigned MATRIX_SIZE  = LINE_SIZE * ROW_COL_SIZE;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} loader_state_e;

  // Bit offset of element (i,j) inside a [0:MATRIX_SIZE-1] flat bus.
  function automatic int unsigned elem_off(input int unsigned i, input int unsigned j);
    return i * LINE_SIZE + j * BIT_SIZE;
  endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Element stream in, matrix pair out. in_last exists only when
// LOADER_LAST_CHECK_EN is defined.
interface matrix_stream_loader_if #(
  parameter int unsigned BIT_SIZE     = matrix_pkg::BIT_SIZE,
  parameter int unsigned ROW_COL_SIZE = matrix_pkg::ROW_COL_SIZE
);

  localparam int unsigned MATRIX_SIZE = BIT_SIZE * ROW_COL_SIZE * ROW_COL_SIZE;

  logic [BIT_SIZE-1:0]    in_data;
  logic                   in_valid;
  logic                   in_ready;
`ifdef LOADER_LAST_CHECK_EN
  logic                   in_last;
`endif
  logic [0:MATRIX_SIZE-1] m1;
  logic [0:MATRIX_SIZE-1] m2;
  logic                   mat_valid;
  logic                   mat_ready;
  logic                   err;

  // Loader side.
  modport master (
`ifdef LOADER_LAST_CHECK_EN
    input  in_last,
`endif
    input  in_data, in_valid, mat_ready,
    output in_ready, m1, m2, mat_valid, err
  );

  // Producer/consumer side.
  modport slave (
`ifdef LOADER_LAST_CHECK_EN
    output in_last,
`endif
    output in_data, in_valid, mat_ready,
    input  in_ready, m1, m2, mat_valid, err
  );

endinterface

// File: rtl/matrix_idx_counter.sv
// Row/column element index for an NxN row-major stream; wrap flags (N-1,N-1).
module matrix_idx_counter #(
  parameter int unsigned ROW_COL_SIZE = 3,
  parameter int unsigned IDX_W        = (ROW_COL_SIZE > 1) ? $clog2(ROW_COL_SIZE) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] Last = IDX_W'(ROW_COL_SIZE - 1);

  logic [IDX_W-1:0] row_q, col_q;

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc) begin
      if (col_q == Last) begin
        col_q <= '0;
        row_q <= (row_q == Last) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign wrap = (row_q == Last) && (col_q == Last);

endmodule

// File: rtl/matrix_stream_loader.sv
// Loads matrix A then B from a byte stream and holds the pair for the multiplier.
// Optional framing check on in_last: define LOADER_LAST_CHECK_EN.
module matrix_stream_loader #(
  parameter int unsigned BIT_SIZE     = matrix_pkg::BIT_SIZE,
  parameter int unsigned ROW_COL_SIZE = matrix_pkg::ROW_COL_SIZE
) (
  input logic                    clk,
  input logic                    n_rst,
  input logic                    clear,
  matrix_stream_loader_if.master bus
);

  import matrix_pkg::*;

  localparam int unsigned LINE_SIZE   = BIT_SIZE * ROW_COL_SIZE;
  localparam int unsigned MATRIX_SIZE = LINE_SIZE * ROW_COL_SIZE;
  localparam int unsigned IDX_W       = (ROW_COL_SIZE > 1) ? $clog2(ROW_COL_SIZE) : 1;
  localparam int unsigned OFF_W       = $clog2(MATRIX_SIZE);

  loader_state_e          state_q;
  logic                   in_ready_q, mat_valid_q, err_q;
  logic [0:MATRIX_SIZE-1] m1_q, m2_q;

  logic [IDX_W-1:0] row, col;
  logic             wrap, xfer, frame_err, idx_clr;
  logic [OFF_W-1:0] off;

  assign xfer = bus.in_valid & in_ready_q;
  assign off  = OFF_W'(row * LINE_SIZE + col * BIT_SIZE);

`ifdef LOADER_LAST_CHECK_EN
  // in_last must be high exactly on the final element of B.
  assign frame_err = xfer & (bus.in_last != ((state_q == LOAD_B) && wrap));
`else
  assign frame_err = 1'b0;
`endif

  assign idx_clr = clear | frame_err;

  matrix_idx_counter #(
    .ROW_COL_SIZE(ROW_COL_SIZE),
    .IDX_W       (IDX_W)
  ) u_idx (
    .clk  (clk),
    .n_rst(n_rst),
    .clear(idx_clr),
    .inc  (xfer),
    .row  (row),
    .col  (col),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= LOAD_A;
      in_ready_q  <= 1'b1;
      mat_valid_q <= 1'b0;
      err_q       <= 1'b0;
      m1_q        <= '0;
      m2_q        <= '0;
    end else if (clear) begin
      state_q     <= LOAD_A;
      in_ready_q  <= 1'b1;
      mat_valid_q <= 1'b0;
    end else if (frame_err) begin
      // Drop the element and resync on the next frame boundary.
      state_q <= LOAD_A;
      err_q   <= 1'b1;
    end else begin
      unique case (state_q)
        LOAD_A: if (xfer) begin
          m1_q[off +: BIT_SIZE] <= bus.in_data;
          if (wrap) state_q <= LOAD_B;
        end
        LOAD_B: if (xfer) begin
          m2_q[off +: BIT_SIZE] <= bus.in_data;
          if (wrap) begin
            state_q     <= FULL;
            in_ready_q  <= 1'b0;
            mat_valid_q <= 1'b1;
          end
        end
        FULL: if (bus.mat_ready) begin
          state_q     <= LOAD_A;
          in_ready_q  <= 1'b1;
          mat_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= LOAD_A;
          in_ready_q  <= 1'b1;
          mat_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mat_valid = mat_valid_q;
  assign bus.m1        = m1_q;
  assign bus.m2        = m2_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader against a frame-level model.
module tb_matrix_stream_loader;

  import matrix_pkg::*;

  localparam int N     = ROW_COL_SIZE;
  localparam int NN    = N * N;
  localparam int FRAME = 2 * NN;
`ifdef LOADER_LAST_CHECK_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  typedef logic [7:0]             frame_t [FRAME];
  typedef logic [7:0]             mat_t   [NN];
  typedef logic [0:MATRIX_SIZE-1] flat_t;

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         mr;
    bit         exp_ir;
    bit         exp_mv;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst, clear;

  matrix_stream_loader_if bus ();

  matrix_stream_loader dut (
    .clk  (clk),
    .n_rst(n_rst),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: accepted-element count within the frame, and a full flag.
  mat_t ma, mb;
  int   mk;
  bit   mfull, merr;

  task automatic check_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_byte(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_flat(string name, flat_t act, flat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no completion, expected completion", name);
  endtask

  function automatic flat_t pack(mat_t e);
    flat_t f = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        f[elem_off(i, j) +: 8] = e[i*N+j];
    return f;
  endfunction

  function automatic flat_t pack_frame(frame_t f, bit second);
    mat_t e;
    for (int k = 0; k < NN; k++) e[k] = second ? f[NN+k] : f[k];
    return pack(e);
  endfunction

  function automatic void model_step(bit v, logic [7:0] d, bit last, bit mr, bit clr, bit rst);
    if (!rst) begin
      for (int k = 0; k < NN; k++) begin
        ma[k] = 8'h00;
        mb[k] = 8'h00;
      end
      mk = 0; mfull = 0; merr = 0;
    end else if (clr) begin
      mk = 0; mfull = 0;
    end else if (mfull) begin
      if (mr) mfull = 0;
    end else if (v) begin
      if (LastEn && (last != (mk == FRAME - 1))) begin
        merr = 1; mk = 0;
      end else begin
        if (mk < NN) ma[mk] = d;
        else         mb[mk-NN] = d;
        mk++;
        if (mk == FRAME) begin
          mk = 0; mfull = 1;
        end
      end
    end
  endfunction

  task automatic cyc(bit v, logic [7:0] d, bit last, bit mr, bit clr, bit rst);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.mat_ready = mr;
    clear         = clr;
    n_rst         = rst;
`ifdef LOADER_LAST_CHECK_EN
    bus.in_last   = last;
`endif
    model_step(v, d, last, mr, clr, rst);
    @(posedge clk);
    #1;
    check_bit("in_ready", bus.in_ready, !mfull);
    check_bit("mat_valid", bus.mat_valid, mfull);
    check_bit("err", bus.err, merr);
    check_flat("m1", bus.m1, pack(ma));
    check_flat("m2", bus.m2, pack(mb));
  endtask

  // Sends n elements of f; in_last flips from its correct value on index bad.
  task automatic feed(frame_t f, int n, int gap, int bad, bit mr);
    int  sent  = 0;
    int  guard = 0;
    bit  v, acc, last;
    while (sent < n && guard < 500) begin
      v    = (int'($urandom_range(99)) >= gap);
      acc  = v && !mfull;
      last = (sent == FRAME - 1) ^ (sent == bad);
      cyc(v, v ? f[sent] : 8'($urandom), last, mr, 1'b0, 1'b1);
      if (acc) sent++;
      guard++;
    end
    if (sent < n) fail_now("feed");
  endtask

  task automatic take(int mr_pct, int max_cyc);
    int g = 0;
    while (mfull && g < max_cyc) begin
      cyc(1'($urandom), 8'($urandom), 1'b0, int'($urandom_range(99)) < mr_pct, 1'b0, 1'b1);
      g++;
    end
    if (mfull) fail_now("take");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f1, f2, f3, fr;
    vec_t   tbl [7];
    int     first_mv, mv_cnt;
    bit     v;

    for (int k = 0; k < NN; k++) begin
      f1[k]    = 8'(k + 1);
      f1[NN+k] = 8'(NN - k);
    end
    for (int k = 0; k < FRAME; k++) begin
      f2[k] = 8'($urandom);
      f3[k] = 8'(8'h10 + k);
    end
    for (int r = 0; r < 5; r++) tbl[r] = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

    // Reset state.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_flat("rst_m1", bus.m1, '0);
    check_flat("rst_m2", bus.m2, '0);
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check_bit("rst_mat_valid", bus.mat_valid, 1'b0);

    // Back-to-back frame, consumer always ready.
    first_mv = -1;
    mv_cnt   = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      v = (i < FRAME);
      cyc(v, v ? f1[i] : 8'h00, i == FRAME - 1, 1'b1, 1'b0, 1'b1);
      if (bus.mat_valid) begin
        mv_cnt++;
        if (first_mv < 0) begin
          first_mv = i;
          for (int j = 0; j < N; j++) begin
            check_byte("m1_row0", bus.m1[elem_off(0, j) +: 8], 8'(j + 1));
            check_byte("m2_row0", bus.m2[elem_off(0, j) +: 8], 8'(NN - j));
          end
        end
      end
    end
    check_int("mv_latency", first_mv, FRAME - 1);
    check_int("mv_width", mv_cnt, 1);

    // Consumer stalls five cycles with extra in_valid.
    feed(f1, FRAME, 0, -1, 1'b0);
    for (int r = 0; r < 7; r++) begin
      cyc(tbl[r].v, tbl[r].d, 1'b0, tbl[r].mr, 1'b0, 1'b1);
      check_bit("tbl_in_ready", bus.in_ready, tbl[r].exp_ir);
      check_bit("tbl_mat_valid", bus.mat_valid, tbl[r].exp_mv);
      if (r < 5) begin
        check_flat("stall_m1", bus.m1, pack_frame(f1, 1'b0));
        check_flat("stall_m2", bus.m2, pack_frame(f1, 1'b1));
      end
    end

    // Random valid gaps give the same matrices.
    feed(f1, FRAME, 50, -1, 1'b0);
    check_flat("gap_m1", bus.m1, pack_frame(f1, 1'b0));
    check_flat("gap_m2", bus.m2, pack_frame(f1, 1'b1));
    take(100, 5);

    // Random frames with random gaps and consumer back-pressure.
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < FRAME; k++) fr[k] = 8'($urandom);
      feed(fr, FRAME, int'($urandom_range(70)), -1, 1'($urandom));
      check_flat("rand_m2", bus.m2, pack_frame(fr, 1'b1));
      take(40, 100);
    end

    // Reset mid-load, then reset while full.
    feed(f2, 4, 0, -1, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    check_flat("rst_mid_m1", bus.m1, '0);
    check_bit("rst_mid_mv", bus.mat_valid, 1'b0);
    feed(f2, FRAME, 20, -1, 1'b0);
    check_flat("after_rst_m1", bus.m1, pack_frame(f2, 1'b0));
    check_flat("after_rst_m2", bus.m2, pack_frame(f2, 1'b1));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("rst_full_ir", bus.in_ready, 1'b1);
    check_bit("rst_full_mv", bus.mat_valid, 1'b0);

    // Clear after 12 elements beats a simultaneous transfer.
    feed(f1, 12, 0, -1, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
    check_flat("clr_keep_m1", bus.m1, pack_frame(f1, 1'b0));
    feed(f3, FRAME, 30, -1, 1'b0);
    check_byte("clr_m1_00", bus.m1[elem_off(0, 0) +: 8], 8'h10);
    check_byte("clr_m2_22", bus.m2[elem_off(N-1, N-1) +: 8], 8'h21);
    // Clear in FULL drops the pair without a handshake.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check_bit("clr_full_mv", bus.mat_valid, 1'b0);
    check_bit("clr_full_ir", bus.in_ready, 1'b1);

`ifdef LOADER_LAST_CHECK_EN
    // in_last on element 5, then missing on the final element.
    feed(f1, 5, 0, 4, 1'b0);
    check_bit("last_early_err", bus.err, 1'b1);
    feed(f3, FRAME, 0, -1, 1'b0);
    check_flat("last_resync_m1", bus.m1, pack_frame(f3, 1'b0));
    check_bit("last_sticky_err", bus.err, 1'b1);
    take(100, 5);
    feed(f2, FRAME, 0, FRAME - 1, 1'b0);
    check_bit("last_missing_mv", bus.mat_valid, 1'b0);
    feed(f1, FRAME, 25, -1, 1'b0);
    check_flat("last_final_m2", bus.m2, pack_frame(f1, 1'b1));
    take(100, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
